ps2_matrix_mapper: RTL and testbench
====================================

Name: ps2_matrix_mapper

Overview:
- Parametrised successor to the fixed 8x8 PS/2-to-matrix decoder.
- Consumes the byte stream from the existing ps2_intf (DATA/VALID) and maintains an active-low ROWS x COLS key matrix.
- The scancode-to-matrix mapping lives in a CPU/loader-programmable map RAM, not hardwired cases.
- Adds E1/Pause swallowing, keyboard-overflow release-all, a row-scanned column readout and a drop flag.

Parameters:
ROWS, 8, number of matrix rows (2..16)
COLS, 8, number of matrix columns (2..16)
RESET_CODE, 9'h078, {ext,code} of the hardware-reset key (F11); never reaches the matrix
RW, $clog2(ROWS), derived: row index width
CW, $clog2(COLS), derived: column index width

Ports:
clk  in  1  system clock
nreset  in  1  asynchronous active-low reset
kb_valid  in  1  one-cycle strobe, kb_data valid
kb_data  in  8  PS/2 set-2 byte
map_we  in  1  map RAM write strobe
map_addr  in  9  {ext,code} entry address
map_wdata  in  1+RW+CW  {en,row,col}; en=0 means unmapped
row_sel  in  ROWS  active-low row drive from the CPU port
col_data  out  COLS  active-low column readback, registered
km  out  ROWS*COLS  flat matrix, bit r*COLS+c, 0 = pressed
resetkey  out  1  1 while RESET_CODE is held
ready  out  1  1 once the map clear has completed
drop_err  out  1  one-cycle pulse when an input byte is discarded

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (nreset).
- Reset values:
  - km all ones, col_data all ones, resetkey 0, ready 0, drop_err 0.
  - FSM enters CLEAR with the address counter at 0.
- CLEAR state:
  - Writes en=0 to map addresses 0..511, one per cycle (512 cycles).
  - Then sets ready=1 and moves to IDLE.
  - kb_valid and map_we are ignored during CLEAR.
- Decoder FSM states: IDLE, EXT (E0 seen), BRK (F0 seen; ext flag held), E1SKIP (3-bit counter), LOOKUP, APPLY.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK with ext=0.
    - E1 -> E1SKIP, count=7.
    - 00 or FF (overflow) -> km all ones and resetkey=0 on the next cycle; stay in IDLE.
    - Any other byte -> LOOKUP, make, address {0,byte}.
  - EXT:
    - F0 -> BRK with ext=1.
    - 12 or 59 (fake shift) -> IDLE, byte ignored.
    - Other byte -> LOOKUP, make, address {1,byte}.
  - BRK: next byte -> LOOKUP, break, address {ext,byte}.
  - E1SKIP: each valid decrements count; at 0 -> IDLE. The Pause sequence never touches the matrix.
  - LOOKUP: synchronous RAM read, one cycle.
  - APPLY:
    - If address == RESET_CODE: resetkey <= make.
    - Else if en: km[row*COLS+col] <= ~make.
    - Else: no change.
    - Then -> IDLE.
  - Entries with row>=ROWS or col>=COLS are treated as unmapped.
- Latency: terminal byte strobed at cycle N -> km/resetkey change visible at N+2.
- Min byte spacing is 3 cycles. A kb_valid in LOOKUP or APPLY is discarded and drop_err pulses next cycle.
- Map writes:
  - Accepted when ready=1, 1 cycle write.
  - A write in the same cycle as a LOOKUP read returns old data for that lookup.
  - A write never alters km already set. Remapping a held key leaves a stuck bit until a release-all or reset.
- col_data is registered. Each bit c is the AND over rows r with row_sel[r]=0 of km[r*COLS+c]; all ones if no row is selected. It updates one cycle after row_sel or km changes.
- Repeated make codes (typematic) rewrite the same value: idempotent.
- nreset asserted mid-sequence: immediate return to CLEAR; the map contents are lost.

Test Plan:
- Reset, then count cycles -> ready rises exactly 512 cycles after nreset deasserts; km all ones.
- Write map[0x01C]={1,row1,col2}; send 1C -> km bit 10 = 0 at N+2. Send F0,1C -> bit 10 = 1.
- Map {1,0x75}={1,row5,col7}; send E0,75 -> bit 47 = 0. Send E0,F0,75 -> bit 47 = 1. Send E0,12 -> km unchanged.
- Send 78 -> resetkey=1, km unchanged. Send F0,78 -> resetkey=0. Send E1,14,77,E1,F0,14,F0,77 -> no km change; FSM returns to IDLE.
- Press three mapped keys, then send 00 -> km all ones next cycle. Drive row_sel=8'hFD -> col_data equals row 1 bits one cycle later.
- Strobe kb_valid at N and N+1 -> second byte dropped, drop_err pulses at N+2; first byte applied normally.

Source files
------------

// File: rtl/ps2_matrix_mapper.sv
// ps2_matrix_mapper: turns the PS/2 set-2 byte stream into an active-low ROWS x COLS key
// matrix. The scancode-to-key mapping comes from a programmable map RAM, which is swept to
// "unmapped" after every reset.
module ps2_matrix_mapper #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter logic [8:0]  RESET_CODE = 9'h078,
    parameter int unsigned RW         = $clog2(ROWS),
    parameter int unsigned CW         = $clog2(COLS)
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic                 kb_valid_i,
    input  logic [7:0]           kb_data_i,
    input  logic                 map_we_i,
    input  logic [8:0]           map_addr_i,
    input  logic [RW+CW:0]       map_wdata_i,
    input  logic [ROWS-1:0]      row_sel_i,
    output logic [COLS-1:0]      col_data_o,
    output logic [ROWS*COLS-1:0] km_o,
    output logic                 resetkey_o,
    output logic                 ready_o,
    output logic                 drop_err_o
);

    localparam int unsigned MW = 1 + RW + CW;

    localparam logic [2:0] StClear  = 3'd0;
    localparam logic [2:0] StIdle   = 3'd1;
    localparam logic [2:0] StExt    = 3'd2;
    localparam logic [2:0] StBrk    = 3'd3;
    localparam logic [2:0] StE1Skip = 3'd4;
    localparam logic [2:0] StLookup = 3'd5;
    localparam logic [2:0] StApply  = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [8:0]           clr_q, clr_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 ext_q, ext_d;
    logic [8:0]           addr_q, addr_d;
    logic                 make_q, make_d;
    logic [ROWS*COLS-1:0] km_q, km_d;
    logic [COLS-1:0]      col_q, col_d;
    logic                 rk_q, rk_d;
    logic                 ready_q, ready_d;
    logic                 drop_q, drop_d;

    logic [MW-1:0]        map_mem_q [512];
    logic [MW-1:0]        rd_q;
    logic                 mem_we;
    logic [8:0]           mem_waddr;
    logic [MW-1:0]        mem_wdata;

    logic                 rd_en;
    logic [RW-1:0]        rd_row;
    logic [CW-1:0]        rd_col;

    assign rd_en  = rd_q[MW-1];
    assign rd_row = rd_q[CW +: RW];
    assign rd_col = rd_q[CW-1:0];

    // Single RAM write port: the clear sweep owns it until ready, then the CPU/loader.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = map_addr_i;
        mem_wdata = map_wdata_i;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = clr_q;
            mem_wdata = '0;
        end else if (map_we_i && ready_q) begin
            mem_we = 1'b1;
        end
    end

    // Map RAM; the LOOKUP read sees pre-write data when a write hits the same cycle.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            map_mem_q[mem_waddr] <= mem_wdata;
        end
        if (state_q == StLookup) begin
            rd_q <= map_mem_q[addr_q];
        end
    end

    // Decoder FSM next state, matrix update and drop detection.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        cnt_d   = cnt_q;
        ext_d   = ext_q;
        addr_d  = addr_q;
        make_d  = make_q;
        km_d    = km_q;
        rk_d    = rk_q;
        ready_d = ready_q;
        drop_d  = 1'b0;

        case (state_q)
            StClear: begin
                clr_d = clr_q + 9'd1;
                if (clr_q == 9'd511) begin
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (kb_valid_i) begin
                    case (kb_data_i)
                        8'hE0: state_d = StExt;
                        8'hF0: begin
                            ext_d   = 1'b0;
                            state_d = StBrk;
                        end
                        8'hE1: begin
                            cnt_d   = 3'd7;
                            state_d = StE1Skip;
                        end
                        // Keyboard buffer overflow: release everything.
                        8'h00, 8'hFF: begin
                            km_d = '1;
                            rk_d = 1'b0;
                        end
                        default: begin
                            addr_d  = {1'b0, kb_data_i};
                            make_d  = 1'b1;
                            state_d = StLookup;
                        end
                    endcase
                end
            end
            StExt: begin
                if (kb_valid_i) begin
                    case (kb_data_i)
                        8'hF0: begin
                            ext_d   = 1'b1;
                            state_d = StBrk;
                        end
                        // Fake shifts emitted around extended keys carry no key state.
                        8'h12, 8'h59: state_d = StIdle;
                        default: begin
                            addr_d  = {1'b1, kb_data_i};
                            make_d  = 1'b1;
                            state_d = StLookup;
                        end
                    endcase
                end
            end
            StBrk: begin
                if (kb_valid_i) begin
                    addr_d  = {ext_q, kb_data_i};
                    make_d  = 1'b0;
                    state_d = StLookup;
                end
            end
            StE1Skip: begin
                if (kb_valid_i) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            StLookup: begin
                drop_d  = kb_valid_i;
                state_d = StApply;
            end
            StApply: begin
                drop_d = kb_valid_i;
                if (addr_q == RESET_CODE) begin
                    rk_d = make_q;
                end else if (rd_en) begin
                    // Out-of-range row/col never matches a loop index, so it stays unmapped.
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            if (rd_row == r[RW-1:0] && rd_col == c[CW-1:0]) begin
                                km_d[r*COLS+c] = ~make_q;
                            end
                        end
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Column readback: AND of the selected (low) rows, all ones when none is selected.
    always_comb begin
        col_d = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (!row_sel_i[r]) begin
                    col_d[c] = col_d[c] & km_q[r*COLS+c];
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= StClear;
            clr_q   <= '0;
            cnt_q   <= '0;
            ext_q   <= 1'b0;
            addr_q  <= '0;
            make_q  <= 1'b0;
            km_q    <= '1;
            col_q   <= '1;
            rk_q    <= 1'b0;
            ready_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            ext_q   <= ext_d;
            addr_q  <= addr_d;
            make_q  <= make_d;
            km_q    <= km_d;
            col_q   <= col_d;
            rk_q    <= rk_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
        end
    end

    assign km_o       = km_q;
    assign col_data_o = col_q;
    assign resetkey_o = rk_q;
    assign ready_o    = ready_q;
    assign drop_err_o = drop_q;

endmodule

// File: tb/tb_ps2_matrix_mapper.sv
// tb_ps2_matrix_mapper: directed and randomized checks of ps2_matrix_mapper against a
// byte-level reference model of the key matrix.
module tb_ps2_matrix_mapper;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic        clk = 1'b0;
    logic        nreset;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        map_we;
    logic [8:0]  map_addr;
    logic [6:0]  map_wdata;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic [63:0] km;
    logic        resetkey;
    logic        ready;
    logic        drop_err;

    always #5 clk = ~clk;

    ps2_matrix_mapper #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .RESET_CODE (9'h078)
    ) dut (
        .clk_i       (clk),
        .nreset_i    (nreset),
        .kb_valid_i  (kb_valid),
        .kb_data_i   (kb_data),
        .map_we_i    (map_we),
        .map_addr_i  (map_addr),
        .map_wdata_i (map_wdata),
        .row_sel_i   (row_sel),
        .col_data_o  (col_data),
        .km_o        (km),
        .resetkey_o  (resetkey),
        .ready_o     (ready),
        .drop_err_o  (drop_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pressed-key set as a flat bit array plus the map table.
    logic [63:0] mkm;
    logic        mrk;
    bit          men [512];
    int          mrow [512];
    int          mcol [512];
    int          e1_left;
    bit          pend_ext;
    bit          pend_brk;

    logic [7:0]  pool [12] = '{8'h1C, 8'h1B, 8'h23, 8'h75, 8'h78, 8'h2B,
                               8'h34, 8'h12, 8'h59, 8'h6B, 8'h74, 8'h1D};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mkm      = '1;
        mrk      = 1'b0;
        e1_left  = 0;
        pend_ext = 1'b0;
        pend_brk = 1'b0;
        for (int i = 0; i < 512; i++) begin
            men[i] = 1'b0;
            mrow[i] = 0;
            mcol[i] = 0;
        end
    endtask

    task automatic model_key(input bit ext, input logic [7:0] code, input bit make);
        int a;
        a = int'({ext, code});
        if (a == 'h078) mrk = make;
        else if (men[a]) mkm[mrow[a]*COLS + mcol[a]] = !make;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (e1_left > 0) begin
            e1_left--;
            return;
        end
        if (!pend_brk) begin
            if (b == 8'hF0) begin
                pend_brk = 1'b1;
                return;
            end
            if (!pend_ext) begin
                if (b == 8'hE0) begin
                    pend_ext = 1'b1;
                    return;
                end
                if (b == 8'hE1) begin
                    e1_left = 7;
                    return;
                end
                if (b == 8'h00 || b == 8'hFF) begin
                    mkm = '1;
                    mrk = 1'b0;
                    return;
                end
            end else if (b == 8'h12 || b == 8'h59) begin
                pend_ext = 1'b0;
                return;
            end
        end
        model_key(pend_ext, b, !pend_brk);
        pend_ext = 1'b0;
        pend_brk = 1'b0;
    endtask

    function automatic logic [7:0] model_col(input logic [7:0] rs);
        logic [7:0] col;
        col = '1;
        for (int r = 0; r < ROWS; r++)
            if (!rs[r])
                for (int c = 0; c < COLS; c++) col[c] = col[c] & mkm[r*COLS + c];
        return col;
    endfunction

    // Called at a negedge; returns at the negedge after the byte has fully taken effect.
    task automatic send(input logic [7:0] b);
        kb_valid = 1'b1;
        kb_data  = b;
        @(negedge clk);
        kb_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_byte(b);
    endtask

    task automatic map_write(input int a, input bit en, input int row, input int col);
        map_we    = 1'b1;
        map_addr  = a[8:0];
        map_wdata = {en, row[2:0], col[2:0]};
        @(negedge clk);
        map_we    = 1'b0;
        men[a]    = en;
        mrow[a]   = row;
        mcol[a]   = col;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_km"}, km, mkm);
        check({tag, "_rk"}, resetkey, mrk);
    endtask

    initial begin
        logic [7:0] b;
        int         r;
        nreset    = 1'b0;
        kb_valid  = 1'b0;
        kb_data   = '0;
        map_we    = 1'b0;
        map_addr  = '0;
        map_wdata = '0;
        row_sel   = '1;
        model_reset();

        #12;
        check("rst_km", km, {64{1'b1}});
        check("rst_col", col_data, 8'hFF);
        check("rst_rk", resetkey, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_drop", drop_err, 1'b0);

        // Map clear takes exactly 512 cycles after reset release.
        @(negedge clk);
        nreset = 1'b1;
        repeat (511) @(negedge clk);
        check("ready_early", ready, 1'b0);
        @(negedge clk);
        check("ready_rise", ready, 1'b1);
        check("ready_km", km, {64{1'b1}});

        // Make latency: visible two edges after the sampling edge, not earlier.
        map_write('h01C, 1'b1, 1, 2);
        kb_valid = 1'b1;
        kb_data  = 8'h1C;
        @(negedge clk);
        kb_valid = 1'b0;
        check("lat_e0", km[10], 1'b1);
        @(negedge clk);
        check("lat_e1", km[10], 1'b1);
        @(negedge clk);
        check("lat_e2", km[10], 1'b0);
        model_byte(8'h1C);
        check_state("make_1c");
        send(8'hF0);
        send(8'h1C);
        check("brk_1c_bit", km[10], 1'b1);
        check_state("brk_1c");

        // Extended key, extended break, fake shift.
        map_write('h175, 1'b1, 5, 7);
        send(8'hE0);
        send(8'h75);
        check("make_e075_bit", km[47], 1'b0);
        check_state("make_e075");
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("brk_e075_bit", km[47], 1'b1);
        send(8'hE0);
        send(8'h12);
        check_state("fake_shift");

        // Reset key and Pause swallowing.
        send(8'h78);
        check("rk_make", resetkey, 1'b1);
        check_state("rk_make");
        send(8'hF0);
        send(8'h78);
        check("rk_brk", resetkey, 1'b0);
        foreach (pool[i]) begin
            if (i == 0) begin
                send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
                send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
            end
        end
        check_state("pause");
        send(8'h1C);
        check("post_pause_bit", km[10], 1'b0);

        // Row-scanned readback, then overflow release-all.
        map_write('h01B, 1'b1, 0, 3);
        map_write('h023, 1'b1, 2, 4);
        send(8'h1B);
        send(8'h23);
        row_sel = 8'hFD;
        @(negedge clk);
        check("col_row1_const", col_data, 8'hFB);
        check("col_row1", col_data, model_col(8'hFD));
        row_sel = 8'hFA;
        @(negedge clk);
        check("col_row02", col_data, model_col(8'hFA));
        kb_valid = 1'b1;
        kb_data  = 8'h00;
        @(negedge clk);
        kb_valid = 1'b0;
        check("ovf_km", km, {64{1'b1}});
        @(negedge clk);
        @(negedge clk);
        model_byte(8'h00);
        check("ovf_col", col_data, 8'hFF);

        // Map write colliding with the lookup read uses the old entry; remap leaves bit stuck.
        kb_valid = 1'b1;
        kb_data  = 8'h1C;
        @(negedge clk);
        kb_valid  = 1'b0;
        map_we    = 1'b1;
        map_addr  = 9'h01C;
        map_wdata = {1'b1, 3'd3, 3'd3};
        @(negedge clk);
        map_we = 1'b0;
        @(negedge clk);
        model_byte(8'h1C);
        mrow['h01C] = 3;
        mcol['h01C] = 3;
        check("wr_lookup_old", km[10], 1'b0);
        check("wr_lookup_new", km[27], 1'b1);
        send(8'hF0);
        send(8'h1C);
        check("stuck_bit", km[10], 1'b0);
        check_state("stuck");
        send(8'hFF);
        check_state("ovf_ff");

        // Back-to-back strobes: second byte dropped, first applied.
        kb_valid = 1'b1;
        kb_data  = 8'h1B;
        @(negedge clk);
        kb_data  = 8'h23;
        check("drop_pre", drop_err, 1'b0);
        @(negedge clk);
        kb_valid = 1'b0;
        check("drop_pulse", drop_err, 1'b1);
        @(negedge clk);
        check("drop_end", drop_err, 1'b0);
        model_byte(8'h1B);
        check_state("drop_first");
        send(8'hF0);
        send(8'h1B);

        // Randomized traffic with occasional remaps and row scans.
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                b = pool[$urandom_range(0, 11)];
                map_write(int'({1'($urandom_range(0, 1)), b}), 1'($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            end else begin
                if (r < 20) b = 8'hE0;
                else if (r < 38) b = 8'hF0;
                else if (r < 40) b = 8'hE1;
                else if (r < 42) b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
                else if (r < 46) b = 8'($urandom);
                else b = pool[$urandom_range(0, 11)];
                send(b);
                check_state("rand");
            end
            if (it % 16 == 0) begin
                row_sel = 8'($urandom);
                @(negedge clk);
                check("rand_col", col_data, model_col(row_sel));
            end
        end

        // Asynchronous reset mid-sequence loses the map.
        send(8'hF0);
        #3;
        nreset = 1'b0;
        #1;
        check("mid_rst_km", km, {64{1'b1}});
        check("mid_rst_ready", ready, 1'b0);
        check("mid_rst_rk", resetkey, 1'b0);
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        repeat (512) @(negedge clk);
        check("mid_rst_ready_rise", ready, 1'b1);
        send(8'h1C);
        send(8'h1B);
        check("map_lost", km, {64{1'b1}});
        check_state("map_lost");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
